// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB-first shift
// registers, and a carry flip-flop between bits.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             load;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             sub_r, c_r, c_msb_in;
  logic             fa_s, fa_co;

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0] ^ sub_r),
    .ci (c_r),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      sub_r    <= 1'b0;
      c_r      <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      s_sh  <= '0;
      sub_r <= sub;
      c_r   <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      c_r  <= fa_co;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= {fa_s, s_sh[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      // Carry leaving bit WIDTH-2 is the carry into the MSB.
      if (cnt == PENULT) c_msb_in <= fa_co;
      if (cnt == LAST) begin
        sum  <= {fa_s, s_sh[WIDTH-1:1]};
        cout <= fa_co;
        ovf  <= c_msb_in ^ fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   run_len = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all output sampling happens on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      check("busy_done_exclusive", {31'd0, busy & done}, 0);
      if (busy) run_len++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", {24'd0, sum}, {24'd0, e.s});
          check("cout", {31'd0, cout}, {31'd0, e.c});
          check("ovf", {31'd0, ovf}, {31'd0, e.o});
          check("done_cycle", cyc, e.cyc);
          check("busy_len", run_len, W);
        end
        run_len = 0;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 'x;
    b = 'x;
    sub = 1'bx;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    sb.push_back('{es, ec, eo, cyc + 1 + W});
    drive(av, bv, sv);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 4 * W; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    check("busy_after_start", {31'd0, busy}, 1);
    wait_drain();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); wait_drain();
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); wait_drain();
    issue(8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0); wait_drain();
    issue(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0); wait_drain();
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1); wait_drain();

    // start mid-RUN is ignored; the in-flight result must still appear
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(8'hAA, 8'h55, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    check("sum_hold", {24'd0, sum}, 32'h46);

    // back-to-back: start held in the done cycle
    issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    for (int n = 0; n < 4 * W; n++) begin
      if (done) break;
      @(negedge clk);
    end
    check("b2b_done_seen", {31'd0, done}, 1);
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    check("b2b_busy_next", {31'd0, busy}, 1);
    check("b2b_sum_held", {24'd0, sum}, 32'h03);
    wait_drain();

    // abort at cnt=3
    drive(8'h11, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout_ovf", {30'd0, cout, ovf}, 0);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 0);

    issue(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0); wait_drain();
    issue(8'h40, 8'hC0, 1'b1, 8'h80, 1'b0, 1'b1); wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
